// File: rtl/count_checker.sv
// count_checker: locks onto the incrementing UART byte stream and scores good, bad and loss-of-lock events.
// Registered outputs, one-cycle latency, a byte accepted every cycle with no backpressure; `COUNT_CHECKER_LAST_ERR_EN adds mismatch capture.
module count_checker #(
  parameter int CNT_W         = 16,
  parameter int LOSS_THRESH   = 4,
  parameter int RELOCK_THRESH = 2
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Rx_DV,
  input  logic [7:0]       i_Rx_Byte,
  input  logic             i_Clr,
  output logic             o_Locked,
  output logic [7:0]       o_Expected,
  output logic             o_Err_Pulse,
  output logic [CNT_W-1:0] o_Good_Count,
  output logic [CNT_W-1:0] o_Err_Count,
  output logic [7:0]       o_Loss_Count,
  output logic [7:0]       o_Last_Got,
  output logic [7:0]       o_Last_Exp
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOCKED = 2'd1;
  localparam logic [1:0] S_LOST   = 2'd2;
  localparam logic [3:0] LOSS_T   = 4'(LOSS_THRESH);
  localparam logic [3:0] RELOCK_T = 4'(RELOCK_THRESH);

  logic [1:0]       r_State;
  logic [3:0]       r_Miss_Streak;
  logic [3:0]       r_Hit_Streak;
  logic [7:0]       r_Expected;
  logic             r_Err_Pulse;
  logic [CNT_W-1:0] r_Good_Count;
  logic [CNT_W-1:0] r_Err_Count;
  logic [7:0]       r_Loss_Count;

  logic w_Match;
  logic w_Active;
  logic w_Good_Inc;
  logic w_Err_Inc;
  logic w_Lose;
  logic w_Relock;

  // The IDLE anchor byte is neither a match nor a mismatch.
  assign w_Match    = (i_Rx_Byte == r_Expected);
  assign w_Active   = i_Rx_DV && (r_State != S_IDLE);
  assign w_Good_Inc = w_Active && w_Match;
  assign w_Err_Inc  = w_Active && !w_Match;
  assign w_Lose     = w_Err_Inc && (r_State == S_LOCKED) && ((r_Miss_Streak + 4'd1) == LOSS_T);
  assign w_Relock   = w_Good_Inc && (r_State == S_LOST) && ((r_Hit_Streak + 4'd1) == RELOCK_T);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      r_State       <= S_IDLE;
      r_Miss_Streak <= 4'd0;
      r_Hit_Streak  <= 4'd0;
      r_Expected    <= 8'h00;
    end else if (i_Rx_DV) begin
      r_Expected <= i_Rx_Byte + 8'd1;
      case (r_State)
        S_IDLE: begin
          r_State       <= S_LOCKED;
          r_Miss_Streak <= 4'd0;
          r_Hit_Streak  <= 4'd0;
        end
        S_LOCKED: begin
          if (w_Match) begin
            r_Miss_Streak <= 4'd0;
          end else if (w_Lose) begin
            r_State       <= S_LOST;
            r_Miss_Streak <= 4'd0;
            r_Hit_Streak  <= 4'd0;
          end else begin
            r_Miss_Streak <= r_Miss_Streak + 4'd1;
          end
        end
        S_LOST: begin
          if (!w_Match) begin
            r_Hit_Streak <= 4'd0;
          end else if (w_Relock) begin
            r_State       <= S_LOCKED;
            r_Hit_Streak  <= 4'd0;
            r_Miss_Streak <= 4'd0;
          end else begin
            r_Hit_Streak <= r_Hit_Streak + 4'd1;
          end
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      r_Err_Pulse <= 1'b0;
    end else begin
      r_Err_Pulse <= w_Err_Inc;
    end
  end

  // Clear wins over a same-cycle increment; the FSM above ignores it.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n || i_Clr) begin
      r_Good_Count <= '0;
      r_Err_Count  <= '0;
      r_Loss_Count <= 8'h00;
    end else begin
      if (w_Good_Inc && (r_Good_Count != {CNT_W{1'b1}})) begin
        r_Good_Count <= r_Good_Count + 1'b1;
      end
      if (w_Err_Inc && (r_Err_Count != {CNT_W{1'b1}})) begin
        r_Err_Count <= r_Err_Count + 1'b1;
      end
      if (w_Lose && (r_Loss_Count != 8'hFF)) begin
        r_Loss_Count <= r_Loss_Count + 8'd1;
      end
    end
  end

`ifdef COUNT_CHECKER_LAST_ERR_EN
  logic [7:0] r_Last_Got;
  logic [7:0] r_Last_Exp;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      r_Last_Got <= 8'h00;
      r_Last_Exp <= 8'h00;
    end else if (w_Err_Inc) begin
      r_Last_Got <= i_Rx_Byte;
      r_Last_Exp <= r_Expected;
    end
  end

  assign o_Last_Got = r_Last_Got;
  assign o_Last_Exp = r_Last_Exp;
`else
  assign o_Last_Got = 8'h00;
  assign o_Last_Exp = 8'h00;
`endif

  assign o_Locked     = (r_State == S_LOCKED);
  assign o_Expected   = r_Expected;
  assign o_Err_Pulse  = r_Err_Pulse;
  assign o_Good_Count = r_Good_Count;
  assign o_Err_Count  = r_Err_Count;
  assign o_Loss_Count = r_Loss_Count;

endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker: directed scenarios plus a randomized stream scored against a behavioural model.
module tb_count_checker;
  localparam int CW   = 8;
  localparam int LT   = 4;
  localparam int RT   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dv = 1'b0;
  logic          clr = 1'b0;
  logic [7:0]    rx = 8'h00;
  logic          o_locked;
  logic [7:0]    o_expected;
  logic          o_err_pulse;
  logic [CW-1:0] o_good;
  logic [CW-1:0] o_err;
  logic [7:0]    o_loss;
  logic [7:0]    o_last_got;
  logic [7:0]    o_last_exp;

  always #5 clk = ~clk;

  count_checker #(.CNT_W(CW), .LOSS_THRESH(LT), .RELOCK_THRESH(RT)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Rx_DV(dv), .i_Rx_Byte(rx), .i_Clr(clr),
    .o_Locked(o_locked), .o_Expected(o_expected), .o_Err_Pulse(o_err_pulse),
    .o_Good_Count(o_good), .o_Err_Count(o_err), .o_Loss_Count(o_loss),
    .o_Last_Got(o_last_got), .o_Last_Exp(o_last_exp)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: "anchored" = seen a byte since reset, run counters are plain ints.
  bit         m_anch, m_locked, m_pulse;
  int         m_miss_run, m_hit_run, m_good, m_err, m_loss;
  logic [7:0] m_exp, m_cap_got, m_cap_exp;

  function automatic void model_reset();
    m_anch = 0; m_locked = 0; m_pulse = 0;
    m_miss_run = 0; m_hit_run = 0;
    m_good = 0; m_err = 0; m_loss = 0;
    m_exp = 8'h00; m_cap_got = 8'h00; m_cap_exp = 8'h00;
  endfunction

  function automatic void model_step(input bit v, input logic [7:0] b, input bit c);
    m_pulse = 0;
    if (v) begin
      if (!m_anch) begin
        m_anch = 1;
        m_locked = 1;
      end else if (b == m_exp) begin
        if (m_good < CMAX) m_good = m_good + 1;
        if (m_locked) m_miss_run = 0;
        else begin
          m_hit_run = m_hit_run + 1;
          if (m_hit_run >= RT) begin m_locked = 1; m_hit_run = 0; m_miss_run = 0; end
        end
      end else begin
        if (m_err < CMAX) m_err = m_err + 1;
        m_pulse = 1;
        m_cap_got = b;
        m_cap_exp = m_exp;
        if (m_locked) begin
          m_miss_run = m_miss_run + 1;
          if (m_miss_run >= LT) begin
            m_locked = 0; m_miss_run = 0; m_hit_run = 0;
            if (m_loss < 255) m_loss = m_loss + 1;
          end
        end else m_hit_run = 0;
      end
      m_exp = b + 8'd1;
    end
    if (c) begin m_good = 0; m_err = 0; m_loss = 0; end
  endfunction

  function automatic logic [7:0] want_got();
`ifdef COUNT_CHECKER_LAST_ERR_EN
    return m_cap_got;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [7:0] want_exp();
`ifdef COUNT_CHECKER_LAST_ERR_EN
    return m_cap_exp;
`else
    return 8'h00;
`endif
  endfunction

  task automatic cycle(input bit v, input logic [7:0] b, input bit c, input bit r);
    @(negedge clk);
    dv = v; rx = b; clr = c; rst_n = !r;
    @(posedge clk);
    if (r) model_reset(); else model_step(v, b, c);
    #1;
    dv = 0; clr = 0; rst_n = 1;
  endtask

  task automatic test_reset();
    cycle(1, 8'hA5, 1, 1);
    cycle(1, 8'h3C, 0, 1);
    n_vec++; if (o_locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got %0b want 0", o_locked); end
    n_vec++; if (o_expected !== 8'h00) begin n_bad++; $display("FAIL reset_expected got %h want 00", o_expected); end
    n_vec++; if (o_err_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse got %0b want 0", o_err_pulse); end
    n_vec++; if ({o_good, o_err, o_loss} !== '0) begin n_bad++; $display("FAIL reset_counts got %0d/%0d/%0d want 0/0/0", o_good, o_err, o_loss); end
    n_vec++; if ({o_last_got, o_last_exp} !== 16'h0000) begin n_bad++; $display("FAIL reset_last got %h/%h want 00/00", o_last_got, o_last_exp); end
  endtask

  task automatic test_lock();
    cycle(1, 8'h10, 0, 0);
    n_vec++; if (o_locked !== 1'b1) begin n_bad++; $display("FAIL lock_after_anchor got %0b want 1", o_locked); end
    n_vec++; if (o_good !== CW'(0)) begin n_bad++; $display("FAIL anchor_not_counted got %0d want 0", o_good); end
    cycle(1, 8'h11, 0, 0);
    cycle(1, 8'h12, 0, 0);
    n_vec++; if (o_good !== CW'(2)) begin n_bad++; $display("FAIL lock_good got %0d want 2", o_good); end
    n_vec++; if (o_err !== CW'(0)) begin n_bad++; $display("FAIL lock_err got %0d want 0", o_err); end
    n_vec++; if (o_expected !== 8'h13) begin n_bad++; $display("FAIL lock_expected got %h want 13", o_expected); end
  endtask

  task automatic test_wrap();
    logic [7:0] seq [4];
    seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    cycle(1, seq[0], 0, 0);  // re-anchors 0x13 -> 0xFE with one mismatch
    for (int i = 1; i < 4; i++) begin
      cycle(1, seq[i], 0, 0);
      n_vec++; if (o_err_pulse !== 1'b0) begin n_bad++; $display("FAIL wrap_pulse byte %h got %0b want 0", seq[i], o_err_pulse); end
    end
    n_vec++; if (o_expected !== 8'h02) begin n_bad++; $display("FAIL wrap_expected got %h want 02", o_expected); end
    n_vec++; if (o_locked !== 1'b1) begin n_bad++; $display("FAIL wrap_locked got %0b want 1", o_locked); end
  endtask

  task automatic test_mismatch();
    int err_before;
    cycle(1, 8'h1F, 0, 0);
    err_before = m_err;
    cycle(1, 8'h55, 0, 0);
    n_vec++; if (o_err_pulse !== 1'b1) begin n_bad++; $display("FAIL mm_pulse got %0b want 1", o_err_pulse); end
    n_vec++; if (o_err !== CW'(err_before + 1)) begin n_bad++; $display("FAIL mm_err got %0d want %0d", o_err, err_before + 1); end
    n_vec++; if (o_expected !== 8'h56) begin n_bad++; $display("FAIL mm_expected got %h want 56", o_expected); end
    n_vec++; if (o_locked !== 1'b1) begin n_bad++; $display("FAIL mm_locked got %0b want 1", o_locked); end
`ifdef COUNT_CHECKER_LAST_ERR_EN
    n_vec++; if (o_last_got !== 8'h55 || o_last_exp !== 8'h20) begin n_bad++; $display("FAIL mm_capture got %h/%h want 55/20", o_last_got, o_last_exp); end
`else
    n_vec++; if (o_last_got !== 8'h00 || o_last_exp !== 8'h00) begin n_bad++; $display("FAIL mm_capture_tied got %h/%h want 00/00", o_last_got, o_last_exp); end
`endif
    cycle(1, 8'h56, 0, 0);
    n_vec++; if (o_err_pulse !== 1'b0) begin n_bad++; $display("FAIL mm_recover_pulse got %0b want 0", o_err_pulse); end
  endtask

  task automatic test_loss_relock();
    logic [7:0] junk [4];
    junk = '{8'h00, 8'h80, 8'h03, 8'h90};
    for (int i = 0; i < 4; i++) begin
      cycle(1, junk[i], 0, 0);
      n_vec++;
      if (o_locked !== (i < 3 ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL loss_locked byte %0d got %0b want %0b", i, o_locked, (i < 3)); end
    end
    n_vec++; if (o_loss !== 8'd1) begin n_bad++; $display("FAIL loss_count got %0d want 1", o_loss); end
    cycle(1, 8'h91, 0, 0);
    n_vec++; if (o_locked !== 1'b0) begin n_bad++; $display("FAIL relock_early got %0b want 0", o_locked); end
    cycle(1, 8'h92, 0, 0);
    n_vec++; if (o_locked !== 1'b1) begin n_bad++; $display("FAIL relock got %0b want 1", o_locked); end
  endtask

  task automatic test_saturation();
    logic [7:0] b;
    b = o_expected;
    for (int i = 0; i < CMAX + 5; i++) begin
      cycle(1, b, 0, 0);
      b = b + 8'd1;
    end
    n_vec++; if (o_good !== CW'(CMAX)) begin n_bad++; $display("FAIL good_saturate got %0d want %0d", o_good, CMAX); end
    n_vec++; if (o_err_pulse !== 1'b0) begin n_bad++; $display("FAIL sat_pulse got %0b want 0", o_err_pulse); end
  endtask

  task automatic test_clear_and_midreset();
    logic [7:0] e;
    e = o_expected;
    cycle(1, e ^ 8'h5A, 1, 0);
    n_vec++; if (o_err !== CW'(0)) begin n_bad++; $display("FAIL clr_err got %0d want 0", o_err); end
    n_vec++; if (o_good !== CW'(0)) begin n_bad++; $display("FAIL clr_good got %0d want 0", o_good); end
    n_vec++; if (o_err_pulse !== 1'b1) begin n_bad++; $display("FAIL clr_pulse got %0b want 1", o_err_pulse); end
    n_vec++; if (o_last_got !== want_got()) begin n_bad++; $display("FAIL clr_keeps_last got %h want %h", o_last_got, want_got()); end
    cycle(1, e ^ 8'h5A + 8'd1, 0, 0);
    cycle(1, 8'h33, 1, 1);
    n_vec++; if ({o_locked, o_expected, o_err_pulse, o_loss, o_last_got, o_last_exp} !== '0 || o_good !== '0 || o_err !== '0) begin
      n_bad++; $display("FAIL midreset got lk=%0b ex=%h p=%0b g=%0d e=%0d l=%0d lg=%h le=%h want all 0", o_locked, o_expected, o_err_pulse, o_good, o_err, o_loss, o_last_got, o_last_exp);
    end
    cycle(1, 8'h40, 0, 0);
    n_vec++; if (o_locked !== 1'b1 || o_expected !== 8'h41 || o_err_pulse !== 1'b0 || o_good !== '0) begin
      n_bad++; $display("FAIL reanchor got lk=%0b ex=%h p=%0b g=%0d want 1/41/0/0", o_locked, o_expected, o_err_pulse, o_good);
    end
  endtask

  task automatic test_random();
    bit v, c, r;
    logic [7:0] b;
    for (int i = 0; i < 4000; i++) begin
      v = ($urandom_range(0, 99) < 75);
      c = ($urandom_range(0, 99) < 2);
      r = ($urandom_range(0, 999) < 4);
      b = ($urandom_range(0, 99) < 60) ? m_exp : 8'($urandom);
      cycle(v, b, c, r);
      n_vec++; if (o_locked !== m_locked) begin n_bad++; $display("FAIL rnd_locked cyc %0d got %0b want %0b", i, o_locked, m_locked); end
      n_vec++; if (o_expected !== m_exp) begin n_bad++; $display("FAIL rnd_expected cyc %0d got %h want %h", i, o_expected, m_exp); end
      n_vec++; if (o_err_pulse !== m_pulse) begin n_bad++; $display("FAIL rnd_pulse cyc %0d got %0b want %0b", i, o_err_pulse, m_pulse); end
      n_vec++; if (o_good !== CW'(m_good)) begin n_bad++; $display("FAIL rnd_good cyc %0d got %0d want %0d", i, o_good, m_good); end
      n_vec++; if (o_err !== CW'(m_err)) begin n_bad++; $display("FAIL rnd_err cyc %0d got %0d want %0d", i, o_err, m_err); end
      n_vec++; if (o_loss !== 8'(m_loss)) begin n_bad++; $display("FAIL rnd_loss cyc %0d got %0d want %0d", i, o_loss, m_loss); end
      n_vec++; if (o_last_got !== want_got() || o_last_exp !== want_exp()) begin
        n_bad++; $display("FAIL rnd_last cyc %0d got %h/%h want %h/%h", i, o_last_got, o_last_exp, want_got(), want_exp());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_wrap();
    test_mismatch();
    test_loss_relock();
    test_saturation();
    test_clear_and_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
